// File: rtl/mem_loader.sv
// Stream-to-SRAM write engine: takes a valid/ready word stream and writes it to consecutive
// addresses of either the vector or the matrix operand memory, with registered write ports.
module mem_loader #(
   parameter int unsigned VEC_ADDRW = 8,
   parameter int unsigned MAT_ADDRW = 9,
   parameter int unsigned VEC_SIZEW = VEC_ADDRW + 1,
   parameter int unsigned MAT_SIZEW = MAT_ADDRW + 1,
   parameter int unsigned DATAW     = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sel,
   input  logic [MAT_ADDRW-1:0] start_addr,
   input  logic [MAT_SIZEW-1:0] num_words,
   input  logic [DATAW-1:0]     s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [VEC_ADDRW-1:0] vec_waddr,
   output logic [DATAW-1:0]     vec_wdata,
   output logic                 vec_wen,
   output logic [MAT_ADDRW-1:0] mat_waddr,
   output logic [DATAW-1:0]     mat_wdata,
   output logic                 mat_wen,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]           state_q, state_d;
   logic                 sel_q, sel_d;
   logic [MAT_ADDRW-1:0] base_q, base_d;
   logic [MAT_SIZEW-1:0] len_q, len_d;
   logic [MAT_SIZEW-1:0] cnt_q, cnt_d;

   logic                 vec_wen_q, vec_wen_d;
   logic [VEC_ADDRW-1:0] vec_waddr_q, vec_waddr_d;
   logic [DATAW-1:0]     vec_wdata_q, vec_wdata_d;
   logic                 mat_wen_q, mat_wen_d;
   logic [MAT_ADDRW-1:0] mat_waddr_q, mat_waddr_d;
   logic [DATAW-1:0]     mat_wdata_q, mat_wdata_d;

   // Offsets wrap silently at the width of the selected memory.
   logic [MAT_ADDRW-1:0] mat_addr;
   logic [VEC_ADDRW-1:0] vec_addr;

   assign mat_addr = base_q + cnt_q[MAT_ADDRW-1:0];
   assign vec_addr = base_q[VEC_ADDRW-1:0] + cnt_q[VEC_ADDRW-1:0];

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      base_d      = base_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      vec_wen_d   = 1'b0;
      vec_waddr_d = vec_waddr_q;
      vec_wdata_d = vec_wdata_q;
      mat_wen_d   = 1'b0;
      mat_waddr_d = mat_waddr_q;
      mat_wdata_d = mat_wdata_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               sel_d   = sel;
               base_d  = start_addr;
               len_d   = num_words;
               cnt_d   = '0;
               state_d = (num_words == '0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            if (s_valid) begin
               cnt_d = cnt_q + MAT_SIZEW'(1);
               if (sel_q) begin
                  mat_wen_d   = 1'b1;
                  mat_waddr_d = mat_addr;
                  mat_wdata_d = s_data;
               end else begin
                  vec_wen_d   = 1'b1;
                  vec_waddr_d = vec_addr;
                  vec_wdata_d = s_data;
               end
               if (cnt_d == len_q) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         sel_q       <= 1'b0;
         base_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         vec_wen_q   <= 1'b0;
         vec_waddr_q <= '0;
         vec_wdata_q <= '0;
         mat_wen_q   <= 1'b0;
         mat_waddr_q <= '0;
         mat_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         base_q      <= base_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         vec_wen_q   <= vec_wen_d;
         vec_waddr_q <= vec_waddr_d;
         vec_wdata_q <= vec_wdata_d;
         mat_wen_q   <= mat_wen_d;
         mat_waddr_q <= mat_waddr_d;
         mat_wdata_q <= mat_wdata_d;
      end
   end

   assign vec_wen   = vec_wen_q;
   assign vec_waddr = vec_waddr_q;
   assign vec_wdata = vec_wdata_q;
   assign mat_wen   = mat_wen_q;
   assign mat_waddr = mat_waddr_q;
   assign mat_wdata = mat_wdata_q;

   // The final write and done share a cycle because DONE follows the last accepted beat.
   assign s_ready = (state_q == StLoad);
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a driver issues bursts and queues the expected write
// sequence; a negedge monitor pops and compares every write / done event.
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sel;
   logic [8:0]  start_addr;
   logic [9:0]  num_words;
   logic [63:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  vec_waddr;
   logic [63:0] vec_wdata;
   logic        vec_wen;
   logic [8:0]  mat_waddr;
   logic [63:0] mat_wdata;
   logic        mat_wen;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   mem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .sel        (sel),
      .start_addr (start_addr),
      .num_words  (num_words),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .vec_waddr  (vec_waddr),
      .vec_wdata  (vec_wdata),
      .vec_wen    (vec_wen),
      .mat_waddr  (mat_waddr),
      .mat_wdata  (mat_wdata),
      .mat_wen    (mat_wen),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      bit          w_vec;
      bit          w_mat;
      bit          dn;
      int          addr;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write or done must match the head of the expected queue, in order.
   logic        rst_seen = 1'b0;
   logic [7:0]  prev_vaddr;
   logic [63:0] prev_vdata;
   logic [8:0]  prev_maddr;
   logic [63:0] prev_mdata;

   always @(posedge clk) rst_seen <= rst;

   always @(negedge clk) begin
      exp_t e;
      if (vec_wen || mat_wen || done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", 64'({vec_wen, mat_wen, done}), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'({vec_wen, mat_wen, done}), 64'({e.w_vec, e.w_mat, e.dn}));
            if (e.w_vec && vec_wen) begin
               check("vec_waddr", 64'(vec_waddr), 64'(e.addr));
               check("vec_wdata", vec_wdata, e.data);
            end
            if (e.w_mat && mat_wen) begin
               check("mat_waddr", 64'(mat_waddr), 64'(e.addr));
               check("mat_wdata", mat_wdata, e.data);
            end
         end
      end
      // Write ports must hold steady while idle, except right after a reset edge.
      if (rst_seen && rst) begin
         if (!vec_wen) begin
            check("vec_hold_addr", 64'(vec_waddr), 64'(prev_vaddr));
            check("vec_hold_data", vec_wdata, prev_vdata);
         end
         if (!mat_wen) begin
            check("mat_hold_addr", 64'(mat_waddr), 64'(prev_maddr));
            check("mat_hold_data", mat_wdata, prev_mdata);
         end
      end
      prev_vaddr = vec_waddr;
      prev_vdata = vec_wdata;
      prev_maddr = mat_waddr;
      prev_mdata = mat_wdata;
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_vec_wen"}, 64'(vec_wen), 64'd0);
      check({tag, "_mat_wen"}, 64'(mat_wen), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      check({tag, "_vec_waddr"}, 64'(vec_waddr), 64'd0);
      check({tag, "_mat_waddr"}, 64'(mat_waddr), 64'd0);
      check({tag, "_wdata"}, vec_wdata | mat_wdata, 64'd0);
   endtask

   // gap_mode: 0 none, 1 two idle cycles after beat 0, 2 random gaps.
   // abort_after >= 0 asserts reset once that many beats have been accepted.
   task automatic burst(input bit s, input int addr, input int n, input bit fixed_data,
                        input int gap_mode, input bit mid_start, input int abort_after);
      logic [63:0] data[$];
      int          n_wr;
      int          budget;
      exp_t        e;
      for (int k = 0; k < n; k++) begin
         data.push_back(fixed_data ? 64'(8'hA0 + k) : {$urandom, $urandom});
      end
      n_wr = (abort_after >= 0) ? abort_after : n;
      for (int k = 0; k < n_wr; k++) begin
         e.w_vec = !s;
         e.w_mat = s;
         e.dn    = (abort_after < 0) && (k == n - 1);
         e.addr  = s ? (addr + k) % 512 : ((addr % 256) + k) % 256;
         e.data  = data[k];
         exp_q.push_back(e);
      end
      if (n == 0) begin
         e.w_vec = 1'b0;
         e.w_mat = 1'b0;
         e.dn    = 1'b1;
         e.addr  = 0;
         e.data  = '0;
         exp_q.push_back(e);
      end

      budget = 0;
      while (busy && budget < 100) begin
         tick();
         budget++;
      end
      check("idle_before_start", 64'(busy), 64'd0);

      start      = 1'b1;
      sel        = s;
      start_addr = 9'(addr);
      num_words  = 10'(n);
      tick();
      start      = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("s_ready_after_start", 64'(s_ready), 64'(n != 0));

      if (n == 0) begin
         check("zero_len_done", 64'(done), 64'd1);
         tick();
         check("zero_len_busy_drop", 64'(busy), 64'd0);
         return;
      end

      for (int k = 0; k < n; k++) begin
         if ((gap_mode == 1 && k == 1) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
            s_valid = 1'b0;
            s_data  = {$urandom, $urandom};
            repeat (gap_mode == 1 ? 2 : $urandom_range(1, 2)) tick();
         end
         s_valid = 1'b1;
         s_data  = data[k];
         if (mid_start && k == n / 2) begin
            start      = 1'b1;
            sel        = !s;
            start_addr = 9'(addr) ^ 9'h55;
            num_words  = 10'($urandom_range(0, 7));
         end
         check("s_ready_in_load", 64'(s_ready), 64'd1);
         tick();
         start = 1'b0;
         if (abort_after == k + 1) begin
            s_valid = 1'b0;
            rst     = 1'b0;
            repeat (3) begin
               tick();
               check_all_zero("abort");
            end
            rst = 1'b1;
            return;
         end
      end
      s_valid = 1'b0;
      check("last_s_ready_low", 64'(s_ready), 64'd0);
      check("last_busy_high", 64'(busy), 64'd1);
      check("last_done", 64'(done), 64'd1);
      tick();
      check("busy_drop", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b1;
      sel        = 1'b1;
      start_addr = 9'h1AB;
      num_words  = 10'd7;
      s_valid    = 1'b1;
      s_data     = {$urandom, $urandom};
      repeat (5) begin
         tick();
         check_all_zero("reset");
      end
      start   = 1'b0;
      s_valid = 1'b0;
      rst     = 1'b1;
      tick();

      burst(1'b1, 3, 4, 1'b1, 0, 1'b0, -1);
      burst(1'b0, 'hFE, 3, 1'b0, 1, 1'b0, -1);
      burst(1'b0, 5, 0, 1'b0, 0, 1'b0, -1);
      burst(1'b1, 20, 8, 1'b0, 0, 1'b1, -1);
      burst(1'b0, 40, 5, 1'b0, 0, 1'b0, 2);
      check("queue_empty_after_abort", 64'(exp_q.size()), 64'd0);
      burst(1'b1, 9, 1, 1'b0, 0, 1'b0, -1);
      burst(1'b1, 510, 4, 1'b0, 2, 1'b0, -1);
      burst(1'b0, 250, 300, 1'b0, 0, 1'b0, -1);

      for (int i = 0; i < 25; i++) begin
         burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
               int'($urandom_range(0, 12)), 1'b0, 2, ($urandom_range(0, 3) == 0), -1);
      end

      repeat (4) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_loader.md
# mem_loader

Stream-to-SRAM write engine for the matrix-vector engine. It accepts a valid/ready word stream and writes it into the vector or matrix operand memory at consecutive addresses, so those memories hold the data the read controller later fetches. Host logic issues one `start` per burst. `done` marks the cycle the final word is written, after which the read controller may be launched.

## Interface
- `VEC_ADDRW`, 8, vector memory address width
- `MAT_ADDRW`, 9, matrix memory address width
- `VEC_SIZEW`, VEC_ADDRW+1, vector word-count width (reference only; not used for ports)
- `MAT_SIZEW`, MAT_ADDRW+1, burst length width
- `DATAW`, 64, memory word width

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  burst request; sampled only in IDLE.
- `sel`  in  1  target: 0 = vector memory, 1 = matrix memory; latched with `start`.
- `start_addr`  in  MAT_ADDRW  first write address; vector target uses bits [VEC_ADDRW-1:0].
- `num_words`  in  MAT_SIZEW  burst length in words.
- `s_data`  in  DATAW  stream data.
- `s_valid`  in  1  stream data valid.
- `s_ready`  out  1  loader accepts stream data.
- `vec_waddr`  out  VEC_ADDRW  vector write address.
- `vec_wdata`  out  DATAW  vector write data.
- `vec_wen`  out  1  vector write enable.
- `mat_waddr`  out  MAT_ADDRW  matrix write address.
- `mat_wdata`  out  DATAW  matrix write data.
- `mat_wen`  out  1  matrix write enable.
- `busy`  out  1  burst in progress (state != IDLE).
- `done`  out  1  one-cycle pulse: burst complete.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - `start`=1 latches `sel`, `start_addr` and `num_words`, and clears the beat counter.
  - If `num_words`=0 the next state is DONE; otherwise LOAD.
  - `start` outside IDLE is ignored.
- LOAD:
  - `s_ready`=1 for the whole state; a beat is accepted when `s_valid`&&`s_ready`.
  - Each accepted beat k (0-based) writes `s_data` to address `start_addr`+k of the selected memory. The other memory's `wen` stays 0.
  - The beat counter increments per accepted beat.
  - Acceptance of beat `num_words`-1 moves the FSM to DONE.
  - `s_valid` gaps stall the burst with no timeout.
- DONE: lasts one cycle with `done`=1, then returns to IDLE.
- Address arithmetic:
  - Addresses are modulo 2^MAT_ADDRW (matrix) or 2^VEC_ADDRW (vector); wrap is silent.
  - For the vector target, `num_words` is not range-checked; bursts longer than 2^VEC_ADDRW overwrite earlier words.
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Reset mid-burst aborts: no further `wen` and no `done`. Words already written remain in memory.

## Timing
- `start` sampled at edge T: `busy`=1 and `s_ready`=1 from cycle T+1.
- Write outputs are registered. A beat accepted at edge E produces `wen`=1 with its address and data during cycle E+1, i.e. one cycle of write latency.
- Throughput is one word per cycle while `s_valid` is held high.
- Last beat accepted at edge L:
  - `s_ready`=0 from cycle L+1.
  - The final `wen` and `done`=1 are asserted together in cycle L+1.
  - `busy`=1 in cycle L+1 and `busy`=0 from cycle L+2.
  - A new `start` is accepted at edge L+2 at the earliest.
- Zero-length burst: `start` at T gives `done`=1 and `busy`=1 in cycle T+1, with no `wen`.
- `wdata`/`waddr` hold their last value when `wen`=0; the value is don't-care but must be stable.
- `s_ready` depends only on state. There is no combinational path from `s_valid` to `s_ready`.

## Test plan
- Reset for 5 cycles with `start`=1 and `s_valid`=1 → all outputs 0; no `wen`.
- `sel`=1, `start_addr`=3, `num_words`=4, data 0xA0..0xA3 back-to-back → `mat_wen` in 4 consecutive cycles at `mat_waddr` 3,4,5,6. `done` coincides with the write to address 6. `vec_wen` stays 0.
- `sel`=0, `start_addr`=0xFE, `num_words`=3, `s_valid` deasserted for 2 cycles after the first beat → `vec_waddr` 0xFE, 0xFF, 0x00 (wrap). There is no write during the gap. Exactly 3 writes, then one `done` pulse.
- `num_words`=0 → one `done` pulse at T+1, no writes; `busy` high for one cycle.
- `start` pulsed mid-burst with different `start_addr` → ignored; addresses continue from the original burst.
- `rst`=0 after 2 of 5 beats → no further `wen` or `done`. After release, a new burst with `start_addr`=9, `num_words`=1 writes address 9.
